// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-stage <-> data-memory interface:
// DSize encodings, responder FSM states and byte-lane helpers.
package cpu_mem_pkg;

  // DSize encodings carried on req_size.
  localparam logic [0:1] SZ_BYTE = 2'b00;
  localparam logic [0:1] SZ_HALF = 2'b01;
  localparam logic [0:1] SZ_WORD = 2'b10;
  localparam logic [0:1] SZ_RSVD = 2'b11;

  // Wait-state counter width; LATENCY is at most 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Big-endian lane enables: lane 0 is bits [0:7] (lowest byte address).
  // off is addr[30:31]. Alignment is not checked here.
  function automatic logic [0:3] lane_mask(input logic [0:1] size,
                                           input logic [0:1] off);
    logic [0:3] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b1000 >> off;
      SZ_HALF: m = off[0] ? 4'b0011 : 4'b1100;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // True for a misaligned access or the reserved size code.
  function automatic logic access_err(input logic [0:1] size,
                                      input logic [0:1] off);
    logic e;
    e = 1'b1;
    case (size)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = off[1];
      SZ_WORD: e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Replicate right-justified store data across every lane it may land in,
  // so the lane mask alone selects the destination bytes.
  function automatic logic [0:31] place_wdata(input logic [0:1]  size,
                                              input logic [0:31] wdata);
    logic [0:31] w;
    w = wdata;
    case (size)
      SZ_BYTE: w = {4{wdata[24:31]}};
      SZ_HALF: w = {2{wdata[16:31]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 32-bit words, four byte-lane write enables
// and a registered read port (read-before-write on the same address).
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [0:3]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [0:31]           wdata,
  output logic [0:31]           rdata
);

  logic [0:31] mem_q [2**DEPTH_LOG2];
  logic [0:31] rdata_q;

  // Per-lane write and registered read on an enabled access.
  // NOTE: the array and its read register have no reset -- a RAM macro cannot
  // be cleared in one cycle; consumers gate rdata until a load completes.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one request, waits LATENCY cycles,
// performs a big-endian lane write or a raw aligned-word read, then pulses
// resp_valid for one cycle. Extension/extraction is left to writeback.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [0:31] req_addr,
  input  logic [0:31] req_wdata,
  input  logic [0:1]  req_size,
  output logic        busy,
  output logic        resp_valid,
  output logic [0:31] resp_rdata,
  output logic        resp_err
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [0:31]      addr_q, addr_d;
  logic [0:31]      wdata_q, wdata_d;
  logic [0:1]       size_q, size_d;
  logic             resp_err_q, resp_err_d;
  // Forces resp_rdata to zero for stores, errors and after reset.
  logic             resp_zero_q, resp_zero_d;

  logic                  req_err;
  logic                  mem_en;
  logic [0:3]            mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [0:31]           mem_rdata;
  logic                  unused_addr_bits;

  // Word index is addr[30-DEPTH_LOG2 : 29]; higher bits alias (wrap).
  assign mem_idx          = addr_q[30-DEPTH_LOG2 +: DEPTH_LOG2];
  assign req_err          = access_err(size_q, addr_q[30:31]);
  assign unused_addr_bits = ^addr_q;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_idx),
    .wdata(place_wdata(size_q, wdata_q)),
    .rdata(mem_rdata)
  );

  // Next-state, request latch and access strobes for the IDLE/WAIT/RESP FSM.
  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    resp_err_d  = resp_err_q;
    resp_zero_d = resp_zero_q;
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    busy        = 1'b0;
    resp_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          cnt_d   = LAT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Commit point: the access happens on this edge.
          mem_en      = 1'b1;
          mem_we      = (write_q && !req_err) ? lane_mask(size_q, addr_q[30:31]) : 4'b0000;
          resp_err_d  = req_err;
          resp_zero_d = write_q || req_err;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset aborts any uncommitted access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_BYTE;
      resp_err_q  <= 1'b0;
      resp_zero_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      resp_err_q  <= resp_err_d;
      resp_zero_q <= resp_zero_d;
    end
  end

  // The array read register only changes at a commit, so this holds until the next RESP.
  assign resp_rdata = resp_zero_q ? 32'h0 : mem_rdata;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// abort / busy-ignore sequences, and random traffic against a byte-array model.
module tb_dmem_responder;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  // Reference memory: 4 KB of bytes, big-endian (lowest address = MSB of word).
  logic [7:0] ref_bytes [4096];

  dmem_responder #(
    .DEPTH_LOG2(10),
    .LATENCY   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request from an idle DUT (called at #1 after a rising edge)
  // and return the response; checks latency, busy and output hold.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] sz,
                        output logic [31:0] rd, output logic er);
    int lat;
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = sz;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd2);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_one_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, "_hold"}, resp_rdata, rd);
  endtask

  // Behavioural model: apply one access to the byte array, produce expectations.
  task automatic model_op(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, output logic [31:0] exp_rd, output logic exp_err);
    int base, nbytes, wb;
    base    = int'(a[11:0]);
    exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_rd  = '0;
    if (!exp_err) begin
      if (wr) begin
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) ref_bytes[base + i] = wd[8*(nbytes-1-i) +: 8];
      end else begin
        wb = base & ~3;
        exp_rd = {ref_bytes[wb], ref_bytes[wb+1], ref_bytes[wb+2], ref_bytes[wb+3]};
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  initial begin
    logic [31:0] rd, exp_rd, a, wd;
    logic        er, exp_er, wr;
    logic [1:0]  sz;
    int          seen;

    vecs[0]  = '{wr:1'b1, addr:32'h0000_0100, wdata:32'h1122_3344, size:2'b10, exp_rdata:32'h0,          exp_err:1'b0};
    vecs[1]  = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         size:2'b10, exp_rdata:32'h1122_3344, exp_err:1'b0};
    vecs[2]  = '{wr:1'b1, addr:32'h0000_0101, wdata:32'h0000_00AB, size:2'b00, exp_rdata:32'h0,          exp_err:1'b0};
    vecs[3]  = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         size:2'b10, exp_rdata:32'h11AB_3344, exp_err:1'b0};
    vecs[4]  = '{wr:1'b1, addr:32'h0000_0102, wdata:32'h0000_BEEF, size:2'b01, exp_rdata:32'h0,          exp_err:1'b0};
    vecs[5]  = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         size:2'b10, exp_rdata:32'h11AB_BEEF, exp_err:1'b0};
    vecs[6]  = '{wr:1'b1, addr:32'h0000_0100, wdata:32'h0000_BEEF, size:2'b01, exp_rdata:32'h0,          exp_err:1'b0};
    vecs[7]  = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         size:2'b10, exp_rdata:32'hBEEF_BEEF, exp_err:1'b0};
    vecs[8]  = '{wr:1'b1, addr:32'h0000_0102, wdata:32'hCAFE_F00D, size:2'b10, exp_rdata:32'h0,          exp_err:1'b1};
    vecs[9]  = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         size:2'b11, exp_rdata:32'h0,          exp_err:1'b1};
    vecs[10] = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         size:2'b10, exp_rdata:32'hBEEF_BEEF, exp_err:1'b0};
    vecs[11] = '{wr:1'b0, addr:32'h0000_1100, wdata:32'h0,         size:2'b10, exp_rdata:32'hBEEF_BEEF, exp_err:1'b0};
    vecs[12] = '{wr:1'b0, addr:32'h0000_0101, wdata:32'h0,         size:2'b01, exp_rdata:32'h0,          exp_err:1'b1};
    vecs[13] = '{wr:1'b0, addr:32'h0000_0103, wdata:32'h0,         size:2'b00, exp_rdata:32'hBEEF_BEEF, exp_err:1'b0};
    vecs[14] = '{wr:1'b0, addr:32'h0000_0102, wdata:32'h0,         size:2'b01, exp_rdata:32'hBEEF_BEEF, exp_err:1'b0};
    vecs[15] = '{wr:1'b1, addr:32'hABC0_1103, wdata:32'hFFFF_FF12, size:2'b00, exp_rdata:32'h0,          exp_err:1'b0};
    vecs[16] = '{wr:1'b0, addr:32'h0000_0100, wdata:32'h0,         size:2'b10, exp_rdata:32'hBEEF_BE12, exp_err:1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",       32'(busy),       32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata,      32'd0);
    check("reset_resp_err",   32'(resp_err),   32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Reset pulsed during WAIT aborts an uncommitted store.
    do_req("prime200", 1'b1, 32'h0000_0200, 32'h0102_0304, 2'b10, rd, er);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0200;
    req_wdata = 32'hDEAD_BEEF;
    req_size  = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #2;
    check("abort_busy_in_reset",  32'(busy),       32'd0);
    check("abort_valid_in_reset", 32'(resp_valid), 32'd0);
    #2;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("abort_no_resp",   seen,       32'd0);
    check("abort_idle_busy", 32'(busy),  32'd0);
    do_req("abort_reload", 1'b0, 32'h0000_0200, 32'h0, 2'b10, rd, er);
    check("abort_reload_rdata", rd, 32'h0102_0304);

    // req_valid held high with a different request while busy: ignored.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0100;
    req_wdata = 32'h0;
    req_size  = 2'b10;
    @(posedge clk); #1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0200;
    req_wdata = 32'h5555_5555;
    seen = 0;
    rd   = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        seen++;
        rd = resp_rdata;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("held_pulses",    seen,      32'd1);
    check("held_rdata",     rd,        32'hBEEF_BE12);
    check("held_idle_busy", 32'(busy), 32'd0);
    do_req("held_reload", 1'b0, 32'h0000_0200, 32'h0, 2'b10, rd, er);
    check("held_reload_rdata", rd, 32'h0102_0304);

    // Random traffic in a 64-byte window (with random aliasing upper bits).
    for (int w = 0; w < 16; w++) begin
      a  = 32'(w * 4);
      wd = $urandom;
      model_op(1'b1, a, wd, 2'b10, exp_rd, exp_er);
      do_req($sformatf("fill%0d", w), 1'b1, a, wd, 2'b10, rd, er);
      check($sformatf("fill%0d_err", w), 32'(er), 32'(exp_er));
    end
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      wd = $urandom;
      model_op(wr, a, wd, sz, exp_rd, exp_er);
      do_req($sformatf("rnd%0d", n), wr, a, wd, sz, rd, er);
      check($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      check($sformatf("rnd%0d_err", n), 32'(er), 32'(exp_er));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory slave that answers load/store requests issued by the pipeline's memory stage. It is the responder end of the memory-stage ↔ data-memory interface.
- Accepts address, store data, size and write enable; applies a configurable number of wait states.
- Performs big-endian byte-lane writes, or returns the raw aligned word on reads. This is the word the memory stage forwards as its load value.
- Sign/zero extension and sub-word extraction stay in writeback (loadSign/DSize), not here.

Parameters:
DEPTH_LOG2, 10, log2 of number of 32-bit words in the array (4 KB default)
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears FSM/outputs, not array contents
req_valid  input  1  request present this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  [0:31]  byte address (bit 0 MSB)
req_wdata  input  [0:31]  store data, right-justified (byte in [24:31], half in [16:31])
req_size  input  [0:1]  DSize encoding: 00 byte, 01 halfword, 10 word, 11 reserved
busy  output  1  high while a request is in flight; pipeline must stall
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  [0:31]  aligned word at req_addr[0:29] (loads); 0 for stores/errors
resp_err  output  1  qualifies resp_valid: misaligned or reserved size

Behaviour:
- Reset values: busy=0, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, counter=0. Memory array is not initialised.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - busy=0.
  - If req_valid, latch addr/wdata/size/write, load counter=LATENCY-1, go to WAIT.
- WAIT:
  - busy=1.
  - If counter≠0, decrement.
  - If counter=0, perform the access on this edge and go to RESP.
- RESP:
  - resp_valid=1 for exactly this cycle, busy=1. Return to IDLE next cycle.
- Timing: request accepted at edge N → resp_valid high in cycle N+LATENCY. The next request can be accepted in the cycle after RESP.
- req_valid while busy=1 is ignored; no queueing.
- Word index = addr[32-2-DEPTH_LOG2 : 29]. Upper address bits are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+2).
- Alignment check, evaluated on the latched request:
  - Halfword requires addr[31]=0.
  - Word requires addr[30:31]=00.
  - Size 11 is always an error.
  - On error: no array write, resp_rdata=0, resp_err=1.
- Store lane mapping (big-endian):
  - Byte: lane k = addr[30:31]. Lane 0 = bits [0:7] … lane 3 = [24:31]. Write wdata[24:31] into that lane.
  - Halfword: addr[30]=0 writes wdata[16:31] into [0:15]; addr[30]=1 writes it into [16:31].
  - Word: all lanes.
  - Other lanes are preserved (read-modify-write within the access cycle, or per-lane write enables).
- Loads: resp_rdata = full stored word, unshifted, for every legal size.
- Stores: resp_rdata=0, resp_err=0.
- Reset asserted in WAIT or RESP aborts the access. An uncommitted store never writes; the FSM returns to IDLE immediately.
- resp_rdata/resp_err hold their values until the next RESP; resp_valid is the only qualifier.

Decomposition:
- Shared package (cpu_mem_pkg):
  - DSize constants: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state typedef.
  - Lane-enable function (size, addr[30:31]) → 4-bit mask, also usable by memory-stage assertions.
- One sub-module, dmem_array: single-port synchronous RAM with 4 byte-lane write enables and a registered read.

Test Plan:
- Word store 0x11223344 @0x00000100, then load @0x100 (LATENCY=2) → resp_valid 2 cycles after each accept; load returns 0x11223344, resp_err=0.
- Byte store wdata=0x000000AB @0x101, load @0x100 → 0x11AB3344.
- Halfword store wdata=0x0000BEEF @0x102, load @0x100 → 0x11ABBEEF. Repeat at 0x100 → 0xBEEFBEEF.
- Word store @0x102 and size=11 load @0x100 → resp_err=1, resp_rdata=0, and a following load @0x100 is unchanged.
- Store 0xDEADBEEF @0x200 with reset pulsed during WAIT → busy=0, resp_valid never fires; load @0x200 returns the prior value.
- req_valid held high with a second address during busy → only the first request is serviced. Also check address wrap: a load at 0x00001100 returns the contents of 0x100 for DEPTH_LOG2=10.
